// File: rtl/mskaes_ks_pkg.sv
// rtl/mskaes_ks_pkg.sv - shared types, round count, RCON table and masked encoding helper for the AES-128 key-schedule sequencer
package mskaes_ks_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } ks_state_t;

    localparam int NROUNDS = 10;

    // Entry 0 is unused; rounds index 1..10.
    localparam logic [10:0][7:0] RCON = {
        8'h36, 8'h1B, 8'h80, 8'h40, 8'h20,
        8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00
    };

    // Bit pos of the d-share encoding of a public byte: share 0 carries the bit, other shares are zero.
    function automatic logic mask_encode_bit(input logic [7:0] v, input int unsigned pos, input int unsigned d);
        return ((pos % d) == 0) ? v[3'(pos / d)] : 1'b0;
    endfunction

endpackage

// File: rtl/mskaes_128bits_ks_ctrl_if.sv
// rtl/mskaes_128bits_ks_ctrl_if.sv - control/status bundle between the key-schedule sequencer and its user
interface mskaes_128bits_ks_ctrl_if #(
    parameter int d = 2
);
    logic           start;
    logic           abort;
    logic           ready;
    logic           busy;
    logic           sel_load;
    logic           key_reg_en;
    logic [8*d-1:0] sh_RCON;
    logic           rk_valid;
    logic [3:0]     rk_idx;
    logic           rnd_req;
    logic           done;

    modport master (
        output start, abort,
        input  ready, busy, sel_load, key_reg_en, sh_RCON, rk_valid, rk_idx, rnd_req, done
    );

    modport slave (
        input  start, abort,
        output ready, busy, sel_load, key_reg_en, sh_RCON, rk_valid, rk_idx, rnd_req, done
    );
endinterface

// File: rtl/mskaes_rcon_gen.sv
// rtl/mskaes_rcon_gen.sv - masked RCON lookup, zero whenever not enabled
module mskaes_rcon_gen
    import mskaes_ks_pkg::*;
#(
    parameter int d = 2
) (
    input  logic [3:0]     i_rnd,
    input  logic           i_en,
    output logic [8*d-1:0] o_sh_rcon
);
    logic [7:0] w_rcon;

    assign w_rcon = (i_rnd <= 4'(NROUNDS)) ? RCON[i_rnd] : 8'h00;

    always_comb begin
        o_sh_rcon = '0;
        if (i_en) begin
            for (int i = 0; i < 8*d; i++) begin
                o_sh_rcon[i] = mask_encode_bit(w_rcon, i, d);
            end
        end
    end
endmodule

// File: rtl/mskaes_128bits_ks_ctrl.sv
// rtl/mskaes_128bits_ks_ctrl.sv - masked AES-128 key-schedule sequencer; MSKAES_KS_RND_GATE_EN gates rnd_req to LOAD/ROUND
module mskaes_128bits_ks_ctrl
    import mskaes_ks_pkg::*;
#(
    parameter int d       = 2,
    parameter int LATENCY = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mskaes_128bits_ks_ctrl_if.slave bus
);
    localparam int              CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0]   CYC_LAST = CW'(LATENCY - 1);

    ks_state_t      r_state, w_state_nxt;
    logic [3:0]     r_rnd, w_rnd_nxt;
    logic [CW-1:0]  r_cyc, w_cyc_nxt;
    logic           w_first, w_last;

    logic           w_ready, w_busy, w_sel_load, w_key_reg_en;
    logic           w_rk_valid, w_done, w_rcon_en;
    logic [3:0]     w_rk_idx;
    logic [8*d-1:0] w_sh_rcon;

    assign w_first = (r_cyc == '0);
    assign w_last  = (r_cyc == CYC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rnd   <= 4'd1;
            r_cyc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rnd   <= w_rnd_nxt;
            r_cyc   <= w_cyc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rnd_nxt   = r_rnd;
        w_cyc_nxt   = r_cyc;
        if (bus.abort) begin
            w_state_nxt = IDLE;
            w_rnd_nxt   = 4'd1;
            w_cyc_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: if (bus.start) w_state_nxt = LOAD;
                LOAD: begin
                    w_state_nxt = ROUND;
                    w_rnd_nxt   = 4'd1;
                    w_cyc_nxt   = '0;
                end
                ROUND: begin
                    if (w_last) begin
                        w_cyc_nxt = '0;
                        if (r_rnd == 4'(NROUNDS)) w_state_nxt = DONE;
                        else                      w_rnd_nxt   = r_rnd + 4'd1;
                    end else begin
                        w_cyc_nxt = r_cyc + CW'(1);
                    end
                end
                DONE: begin
                    w_state_nxt = IDLE;
                    w_rnd_nxt   = 4'd1;
                    w_cyc_nxt   = '0;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        w_ready      = 1'b0;
        w_busy       = 1'b0;
        w_sel_load   = 1'b0;
        w_key_reg_en = 1'b0;
        w_rk_valid   = 1'b0;
        w_rk_idx     = 4'd0;
        w_done       = 1'b0;
        w_rcon_en    = 1'b0;
        case (r_state)
            IDLE: w_ready = 1'b1;
            LOAD: begin
                w_busy       = 1'b1;
                w_sel_load   = 1'b1;
                w_key_reg_en = 1'b1;
            end
            ROUND: begin
                w_busy = 1'b1;
                if (w_first) begin
                    w_rk_valid = 1'b1;
                    w_rk_idx   = r_rnd - 4'd1;
                end
                // Key register captures the round output in the last pipeline cycle.
                if (w_last) begin
                    w_key_reg_en = 1'b1;
                    w_rcon_en    = 1'b1;
                end
            end
            DONE: begin
                w_busy     = 1'b1;
                w_done     = 1'b1;
                w_rk_valid = 1'b1;
                w_rk_idx   = 4'(NROUNDS);
            end
            default: ;
        endcase
    end

    mskaes_rcon_gen #(.d(d)) u_rcon_gen (
        .i_rnd     (r_rnd),
        .i_en      (w_rcon_en),
        .o_sh_rcon (w_sh_rcon)
    );

    assign bus.ready      = w_ready;
    assign bus.busy       = w_busy;
    assign bus.sel_load   = w_sel_load;
    assign bus.key_reg_en = w_key_reg_en;
    assign bus.sh_RCON    = w_sh_rcon;
    assign bus.rk_valid   = w_rk_valid;
    assign bus.rk_idx     = w_rk_idx;
    assign bus.done       = w_done;

`ifdef MSKAES_KS_RND_GATE_EN
    assign bus.rnd_req = (r_state == LOAD) || (r_state == ROUND);
`else
    assign bus.rnd_req = 1'b1;
`endif
endmodule
